// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control block: FSM state encoding and
// the instruction word the stage registers load when flushed.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  // addi x0, x0, 0 -- the canonical RISC-V NOP used as a pipeline bubble
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Width of the memory-wait watchdog counter; covers MEM_TIMEOUT up to 2^16-1
  localparam int WAIT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables and
// bubble controls, data-memory wait state, halt state, memory watchdog and
// a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_halted;
  logic              r_mem_error;
  logic              w_mem_stall;
  logic              w_timeout;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic              w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic              w_if_id_fl, w_id_ex_fl, w_mem_wb_fl;

  assign w_mem_stall = (r_state != ST_HALTED) && dmem_req && !dmem_ready;
  assign w_timeout   = (r_state == ST_MEM_WAIT) && w_mem_stall &&
                       (w_wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // Priority decode of the stage enables and bubbles; first match wins
  always_comb begin
    w_pc_en     = 1'b1;
    w_if_id_en  = 1'b1;
    w_id_ex_en  = 1'b1;
    w_ex_mem_en = 1'b1;
    w_mem_wb_en = 1'b1;
    w_if_id_fl  = 1'b0;
    w_id_ex_fl  = 1'b0;
    w_mem_wb_fl = 1'b0;
    if (r_state == ST_HALTED) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
    end else if (w_mem_stall) begin
      // Freeze everything up to EX/MEM, drain a bubble into MEM/WB
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_fl = 1'b1;
    end else if (branch_taken) begin
      w_if_id_fl  = 1'b1;
      w_id_ex_fl  = 1'b1;
    end else if (load_use_stall) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_fl  = 1'b1;
    end else if (!imem_ready) begin
      w_pc_en     = 1'b0;
      w_if_id_fl  = 1'b1;
    end
  end

  // Reset forces every register to hold a bubble and nothing to advance
  assign pc_en        = rst_n & w_pc_en;
  assign if_id_en     = rst_n & w_if_id_en;
  assign id_ex_en     = rst_n & w_id_ex_en;
  assign ex_mem_en    = rst_n & w_ex_mem_en;
  assign mem_wb_en    = rst_n & w_mem_wb_en;
  assign if_id_flush  = !rst_n | w_if_id_fl;
  assign id_ex_flush  = !rst_n | w_id_ex_fl;
  assign mem_wb_flush = !rst_n | w_mem_wb_fl;

  // Next-state selection; watchdog expiry outranks the ongoing wait
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_timeout)        w_next_state = ST_HALTED;
        else if (w_mem_stall) w_next_state = ST_MEM_WAIT;
        else if (halt_req)    w_next_state = ST_HALTED;
        else                  w_next_state = ST_RUN;
      end
      default: w_next_state = ST_HALTED;
    endcase
  end

  // State register with registered halted and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_halted    <= 1'b0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_halted    <= (w_next_state == ST_HALTED);
      r_mem_error <= r_mem_error | w_timeout;
    end
  end

  assign halted    = r_halted;
  assign mem_error = r_mem_error;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (1'b0),
    .i_inc ((r_state != ST_HALTED) && !w_pc_en),
    .o_cnt (stall_count)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_next_state != ST_MEM_WAIT),
    .i_inc (r_state == ST_MEM_WAIT),
    .o_cnt (w_wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: table-driven single-cycle responses plus
// multi-cycle sequences, with a scoreboard queue of expected enables/flushes.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1;
  logic dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_error;
  logic [31:0] stall_count;

  logic        d2_pc_en, d2_if_id_en, d2_id_ex_en, d2_ex_mem_en, d2_mem_wb_en;
  logic        d2_if_id_flush, d2_id_ex_flush, d2_mem_wb_flush, d2_halted, d2_mem_error;
  logic [3:0]  d2_stall_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .halt_req(halt_req), .pc_en(pc_en),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_error(mem_error),
    .stall_count(stall_count)
  );

  pipeline_ctrl #(.CNT_W(4), .MEM_TIMEOUT(255)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .halt_req(halt_req), .pc_en(d2_pc_en),
    .if_id_en(d2_if_id_en), .id_ex_en(d2_id_ex_en), .ex_mem_en(d2_ex_mem_en),
    .mem_wb_en(d2_mem_wb_en), .if_id_flush(d2_if_id_flush),
    .id_ex_flush(d2_id_ex_flush), .mem_wb_flush(d2_mem_wb_flush),
    .halted(d2_halted), .mem_error(d2_mem_error), .stall_count(d2_stall_count)
  );

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, mem_wb}
  typedef struct {
    logic       lus, br, imr, dreq, drdy, hreq;
    logic [4:0] en;
    logic [2:0] fl;
    logic       hlt;
  } vec_t;

  int total = 0;
  int bad = 0;
  int m_sc = 0;
  int m_sc2 = 0;
  logic [7:0] sb_q[$];
  vec_t tbl[8];

  function automatic vec_t mk(logic lus, logic br, logic imr, logic dreq,
                              logic drdy, logic hreq, logic [4:0] en,
                              logic [2:0] fl, logic hlt);
    vec_t v;
    v.lus = lus; v.br = br; v.imr = imr; v.dreq = dreq; v.drdy = drdy;
    v.hreq = hreq; v.en = en; v.fl = fl; v.hlt = hlt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, compare the
  // combinational response mid-cycle, and advance the stall-count model.
  task automatic apply(input vec_t v, input string name);
    logic [7:0] exp;
    load_use_stall = v.lus; branch_taken = v.br; imem_ready = v.imr;
    dmem_req = v.dreq; dmem_ready = v.drdy; halt_req = v.hreq;
    sb_q.push_back({v.en, v.fl});
    @(negedge clk);
    exp = sb_q.pop_front();
    check(name, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, mem_wb_flush}), 32'(exp));
    if (!v.hlt && !v.en[4]) begin
      m_sc++;
      if (m_sc2 < 15) m_sc2++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_use_stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                              if_id_flush, id_ex_flush, mem_wb_flush}), 32'h07);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mem_error", 32'(mem_error), 32'd0);
    check("rst_stall_count", stall_count, 32'd0);
    m_sc = 0;
    m_sc2 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_state_run", 32'(dut.r_state), 32'(ST_RUN));
  endtask

  vec_t v_idle, v_lus, v_mstall, v_halt_idle;
  int sc_before;

  initial begin
    v_idle      = mk(0,0,1,0,0,0, 5'b11111, 3'b000, 0);
    v_lus       = mk(1,0,1,0,0,0, 5'b00111, 3'b010, 0);
    v_mstall    = mk(0,0,1,1,0,0, 5'b00001, 3'b001, 0);
    v_halt_idle = mk(0,0,1,0,0,0, 5'b00000, 3'b000, 1);

    tbl[0] = v_idle;
    tbl[1] = v_lus;
    tbl[2] = v_idle;
    tbl[3] = mk(1,1,1,0,0,0, 5'b11111, 3'b110, 0);
    tbl[4] = mk(0,0,0,0,0,0, 5'b01111, 3'b100, 0);
    tbl[5] = mk(0,1,0,0,0,0, 5'b11111, 3'b110, 0);
    tbl[6] = mk(1,0,0,0,0,0, 5'b00111, 3'b010, 0);
    tbl[7] = mk(0,1,1,1,1,0, 5'b11111, 3'b110, 0);

    @(posedge clk); #1;
    do_reset();

    // Single-cycle responses in RUN
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (i == 1) check("lus_stall_count", stall_count, 32'd1);
      if (i == 3) check("br_lus_count_same", stall_count, 32'd1);
    end
    check("tbl_stall_count", stall_count, 32'(m_sc));

    // Three-cycle data-memory wait
    sc_before = m_sc;
    for (int i = 0; i < 3; i++) begin
      apply(v_mstall, "mwait_en");
      check("mwait_state", 32'(dut.r_state), 32'(ST_MEM_WAIT));
    end
    apply(mk(0,0,1,1,1,0, 5'b11111, 3'b000, 0), "mwait_release");
    check("mwait_back_run", 32'(dut.r_state), 32'(ST_RUN));
    check("mwait_stall_count", stall_count, 32'(sc_before + 3));

    // Branch held behind a two-cycle memory stall
    apply(mk(0,1,1,1,0,0, 5'b00001, 3'b001, 0), "br_held0");
    apply(mk(0,1,1,1,0,0, 5'b00001, 3'b001, 0), "br_held1");
    apply(mk(0,1,1,1,1,0, 5'b11111, 3'b110, 0), "br_release");
    check("br_stall_count", stall_count, 32'(m_sc));

    // Reset in the middle of a memory wait
    apply(v_mstall, "mw_pre_rst0");
    apply(v_mstall, "mw_pre_rst1");
    do_reset();
    apply(v_idle, "post_rst_idle");

    // Halt request
    apply(mk(0,0,1,0,0,1, 5'b11111, 3'b000, 0), "halt_req_cycle");
    check("halt_halted", 32'(halted), 32'd1);
    sc_before = m_sc;
    apply(mk(1,0,1,0,0,0, 5'b00000, 3'b000, 1), "halt_lus");
    apply(v_halt_idle, "halt_idle");
    check("halt_still", 32'(halted), 32'd1);
    check("halt_count_frozen", stall_count, 32'(sc_before));
    do_reset();

    // Watchdog expiry: entry cycle plus TIMEOUT+1 wait cycles
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      apply(v_mstall, $sformatf("wdog%0d", i));
      if (i == TIMEOUT) check("wdog_not_yet", 32'({halted, mem_error}), 32'd0);
    end
    check("wdog_halted", 32'(halted), 32'd1);
    check("wdog_mem_error", 32'(mem_error), 32'd1);
    check("wdog_stall_count", stall_count, 32'(TIMEOUT + 2));
    apply(mk(0,0,1,0,1,0, 5'b00000, 3'b000, 1), "wdog_hold0");
    apply(v_halt_idle, "wdog_hold1");
    check("wdog_sticky", 32'({halted, mem_error}), 32'd3);
    do_reset();
    check("wdog_rst_wait_cnt", 32'(dut.w_wait_cnt), 32'd0);
    apply(v_idle, "wdog_post_rst");

    // Saturation of a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) apply(v_lus, "sat_lus");
    check("sat_wide_count", stall_count, 32'd20);
    check("sat_narrow_count", 32'(d2_stall_count), 32'(m_sc2));
    check("sat_narrow_max", 32'(d2_stall_count), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Consumes the decode-stage load-use `stall` request, the EX-stage branch redirect, and the instruction and data memory ready handshakes. Drives the per-stage pipeline-register enables and bubble (flush) controls. Adds sequential behaviour: a data-memory wait state, a halt state, a memory-timeout watchdog and a saturating stall-cycle performance counter.

## Interface
- `CNT_W`, 32: width of `stall_count`.
- `MEM_TIMEOUT`, 255: maximum consecutive data-memory wait cycles before an error is raised; legal range 1 to 2^16-1.
- `clk` in 1: pipeline clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_use_stall` in 1: load-use hazard request from the decode-stage hazard unit.
- `branch_taken` in 1: the EX-stage branch or jump redirects the PC.
- `imem_ready` in 1: the fetch word is valid this cycle.
- `dmem_req` in 1: the MEM stage holds a load or store.
- `dmem_ready` in 1: data memory completes the MEM-stage access this cycle.
- `halt_req` in 1: ecall/ebreak has reached the MEM stage.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: stage register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: load a NOP/bubble into the register. Flush applies only when the matching enable is 1.
- `halted` out 1: the core is stopped.
- `mem_error` out 1: sticky flag, data-memory timeout.
- `stall_count` out CNT_W: number of cycles in which the PC did not advance.

## Operation
- FSM states: RUN, MEM_WAIT, HALTED. Reset state is RUN.
- Enable and flush outputs are combinational from the state and the inputs. Priority is evaluated top-down and the first match wins.
  1. HALTED: all enables 0, all flushes 0.
  2. Memory stall, i.e. `dmem_req & ~dmem_ready` in RUN or MEM_WAIT:
     - `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0.
     - `mem_wb_en` = 1 and `mem_wb_flush` = 1.
     - Next state is MEM_WAIT.
  3. `branch_taken`: all enables 1, with `if_id_flush` = 1 and `id_ex_flush` = 1. This overrides `load_use_stall` and `imem_ready`.
  4. `load_use_stall`:
     - `pc_en` = 0 and `if_id_en` = 0.
     - `id_ex_en` = 1 with `id_ex_flush` = 1.
     - EX/MEM and MEM/WB advance.
  5. `~imem_ready`: `pc_en` = 0, `if_id_en` = 1 with `if_id_flush` = 1, and later stages advance.
  6. Otherwise all enables 1 and all flushes 0.
- MEM_WAIT → RUN on the cycle `dmem_ready`=1. In that cycle rules 3–6 apply, so a branch that waited behind the memory access flushes now.
- A branch held during a memory stall is not lost. EX is frozen, so `branch_taken` stays asserted until the stall releases.
- `halt_req` in RUN or MEM_WAIT, with no memory stall active in that cycle: the MEM/WB register loads the halting instruction and the next state is HALTED.
- Watchdog: `wait_cnt` increments each MEM_WAIT cycle and clears on leaving MEM_WAIT. When `wait_cnt` == MEM_TIMEOUT and `dmem_ready` = 0:
  - `mem_error` sets, and it is sticky until reset.
  - Next state is HALTED.
- `stall_count` increments in every non-HALTED cycle with `pc_en` = 0 and saturates at 2^CNT_W-1.
- Only `rst_n` leaves HALTED.

## Timing
- Enables and flushes have zero latency: they react in the same cycle as the inputs.
- State, `wait_cnt`, `stall_count`, `halted` and `mem_error` update on the rising edge of `clk`. `halted` and `mem_error` are registered.
- While `rst_n` = 0, asynchronously:
  - Enables are 0.
  - `if_id_flush`, `id_ex_flush` and `mem_wb_flush` are 1.
  - `halted` = 0, `mem_error` = 0, `stall_count` = 0, `wait_cnt` = 0.
- Reset in the middle of MEM_WAIT abandons the access. The first cycle after deassertion is RUN.
- The load-use stall costs exactly 1 cycle per assertion of the hazard unit. A taken branch costs 2 bubbles.

## Structure
- A shared `pipeline_pkg` holds the FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2) and the NOP encoding 32'h00000013 that the stage registers use on flush.
- One sub-module, `sat_counter` (parameterised width, increment enable, synchronous clear, saturating), is instantiated for both `stall_count` and `wait_cnt`.

## Test plan
- Load-use stall for 1 cycle:
  - Response in that cycle: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
  - Next cycle: all enables 1.
  - `stall_count` = 1.
- `branch_taken`=1 together with `load_use_stall`=1 → `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1, and `stall_count` is unchanged.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles:
  - State is MEM_WAIT, the four upper enables are 0 and `mem_wb_flush`=1 for 3 cycles.
  - Then RUN.
  - `stall_count` = 3.
- `branch_taken` held during a 2-cycle memory stall → no flush while stalled; `if_id_flush`/`id_ex_flush` = 1 in the cycle `dmem_ready` rises.
- MEM_TIMEOUT=4 and `dmem_ready` held low → `mem_error`=1 and `halted`=1 after the timeout. `halted` stays 1 until `rst_n` pulses, then RUN with counters at 0.
- `halt_req` for 1 cycle → `halted`=1 from the next edge and all enables 0. Forcing CNT_W=4 and stalling for 20 cycles → `stall_count` holds at 15.
